// File: rtl/uart_param_pkg.sv
// Shared encodings and width helpers for the parametrised UART core.
// States include PARITY, used only when UART_PARITY_EN is defined.
package uart_param_pkg;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  // Width of a counter indexing 0..n-1 (at least one bit).
  function automatic int unsigned bit_cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of the per-bit baud counter running 0..cpb-1.
  function automatic int unsigned baud_cnt_width(input int unsigned cpb);
    return (cpb < 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: registered storage, wrap-bit pointers, head shown combinationally.
// Push on full without a coincident pop drops the word and pulses overrun_o.
module uart_rx_fifo
  import uart_param_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_l,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             overrun_o
);

  localparam int unsigned AW = bit_cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overrun_q;
  logic             empty_c, full_c, push_ok_c, pop_ok_c;

  always_comb begin
    empty_c   = (wr_ptr_q == rd_ptr_q);
    full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok_c  = pop_i & ~empty_c;
    // A pop in the same cycle frees the slot being written.
    push_ok_c = push_i & (~full_c | pop_i);
    wr_ptr_d  = push_ok_c ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d  = pop_ok_c  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= push_i & full_c & ~pop_i;
      if (push_ok_c) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign valid_o   = ~empty_c;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_param_core.sv
// Full-duplex UART: TX FSM, synchronised RX FSM feeding uart_rx_fifo, sticky errors.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD) and rx_parity_err.
module uart_param_core
  import uart_param_pkg::*;
#(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned CLKS_PER_BIT  = 16,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 4
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_l,
  output logic                 tx_serial,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_done,
  input  logic                 rx_serial,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
`ifdef UART_PARITY_EN
  output logic                 rx_parity_err,
`endif
  input  logic                 err_clr
);

  localparam int unsigned BW = baud_cnt_width(CLKS_PER_BIT);
  localparam int unsigned CW = bit_cnt_width(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  logic [2:0]           tx_state_q, tx_state_d;
  logic [BW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_done_q, tx_done_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  // Transmitter next-state: each bit held CLKS_PER_BIT cycles, LSB first.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_serial_d = tx_serial_q;
    tx_ready_d  = tx_ready_q;
    tx_done_d   = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d    = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        tx_serial_d = 1'b1;
        tx_ready_d  = 1'b1;
        if (tx_valid && tx_ready_q) begin
          tx_state_d  = TX_START;
          tx_shift_d  = tx_data;
          tx_serial_d = 1'b0;
          tx_ready_d  = 1'b0;
          tx_cnt_d    = '0;
`ifdef UART_PARITY_EN
          tx_par_d    = (^tx_data) ^ PARITY_ODD;
`endif
        end
      end
      TX_START: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_state_d  = TX_DATA;
          tx_cnt_d    = '0;
          tx_bit_d    = '0;
          tx_serial_d = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + BW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d    = '0;
`ifdef UART_PARITY_EN
            tx_state_d  = TX_PARITY;
            tx_serial_d = tx_par_q;
`else
            tx_state_d  = TX_STOP;
            tx_serial_d = 1'b1;
`endif
          end else begin
            tx_bit_d    = tx_bit_q + CW'(1);
            tx_shift_d  = tx_shift_q >> 1;
            tx_serial_d = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + BW'(1);
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_state_d  = TX_STOP;
          tx_cnt_d    = '0;
          tx_bit_d    = '0;
          tx_serial_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + BW'(1);
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == STOP_LAST) begin
            tx_state_d = TX_IDLE;
            tx_ready_d = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + CW'(1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + BW'(1);
          // Registered pulse lands in the final cycle of the last stop bit.
          if ((tx_cnt_q == BAUD_PRE) && (tx_bit_q == STOP_LAST)) tx_done_d = 1'b1;
        end
      end
      default: begin
        tx_state_d  = TX_IDLE;
        tx_serial_d = 1'b1;
        tx_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_serial_q <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_done_q   <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q    <= 1'b0;
`endif
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_serial_q <= tx_serial_d;
      tx_ready_q  <= tx_ready_d;
      tx_done_q   <= tx_done_d;
`ifdef UART_PARITY_EN
      tx_par_q    <= tx_par_d;
`endif
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_ready  = tx_ready_q;
  assign tx_done   = tx_done_q;

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [BW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_push_c, frame_err_set_c;
  logic                 rx_frame_err_q, rx_overrun_q, fifo_overrun;
`ifdef UART_PARITY_EN
  logic                 parity_err_set_c, rx_parity_err_q;
`endif

  // Receiver next-state: start checked at half-bit, then one sample per bit period.
  always_comb begin
    rx_state_d      = rx_state_q;
    rx_cnt_d        = rx_cnt_q;
    rx_bit_d        = rx_bit_q;
    rx_shift_d      = rx_shift_q;
    rx_push_c       = 1'b0;
    frame_err_set_c = 1'b0;
`ifdef UART_PARITY_EN
    parity_err_set_c = 1'b0;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == BAUD_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + BW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            rx_bit_d   = '0;
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + CW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + BW'(1);
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d = '0;
          if (rx_s2_q != ((^rx_shift_q) ^ PARITY_ODD)) begin
            parity_err_set_c = 1'b1;
            rx_state_d       = RX_IDLE;
          end else begin
            rx_state_d = RX_STOP;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + BW'(1);
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d = '0;
          if (!rx_s2_q) begin
            frame_err_set_c = 1'b1;
            rx_state_d      = RX_IDLE;
          end else if (rx_bit_q == STOP_LAST) begin
            rx_push_c  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_bit_d = rx_bit_q + CW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + BW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rx_s1_q        <= 1'b1;
      rx_s2_q        <= 1'b1;
      rx_prev_q      <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_frame_err_q <= 1'b0;
      rx_overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err_q <= 1'b0;
`endif
    end else begin
      rx_s1_q        <= rx_serial;
      rx_s2_q        <= rx_s1_q;
      rx_prev_q      <= rx_s2_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      // Set wins over a coincident clear.
      rx_frame_err_q <= frame_err_set_c | (rx_frame_err_q & ~err_clr);
      rx_overrun_q   <= fifo_overrun | (rx_overrun_q & ~err_clr);
`ifdef UART_PARITY_EN
      rx_parity_err_q <= parity_err_set_c | (rx_parity_err_q & ~err_clr);
`endif
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .push_i    (rx_push_c),
    .wdata_i   (rx_shift_q),
    .pop_i     (rx_ready),
    .rdata_o   (rx_data),
    .valid_o   (rx_valid),
    .overrun_o (fifo_overrun)
  );

  assign rx_frame_err = rx_frame_err_q;
  assign rx_overrun   = rx_overrun_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_parity_err_q;
`endif

endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core at default parameters (8 data, 16 clk/bit, 1 stop, depth 4).
// Parity checks are included when UART_PARITY_EN is defined.
module tb_uart_param_core;

  localparam int unsigned CPB = 16;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_l = 1'b0;
  logic       tx_serial;
  logic       tx_valid  = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_ready;
  logic       tx_done;
  logic       rx_serial = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready  = 1'b0;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       err_clr   = 1'b0;
`ifdef UART_PARITY_EN
  logic       rx_parity_err;
  logic       par_flip  = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  uart_param_core dut (
    .sys_clk      (sys_clk),
    .sys_rst_l    (sys_rst_l),
    .tx_serial    (tx_serial),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .rx_serial    (rx_serial),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
`ifdef UART_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .err_clr      (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
`ifdef UART_PARITY_EN
    rx_bit((^d) ^ par_flip);
`endif
    rx_bit(stop);
    rx_serial = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(rx_valid), 1);
    check({tag, "_data"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge sys_clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [10:0] exp_tx;
    int          nbits;

    repeat (3) @(negedge sys_clk);
    check("rst_tx_serial", 32'(tx_serial), 1);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_tx_done", 32'(tx_done), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_frame_err", 32'(rx_frame_err), 0);
    check("rst_overrun", 32'(rx_overrun), 0);
    sys_rst_l = 1'b1;
    repeat (4) @(negedge sys_clk);

    // Transmit one frame; line order start, data LSB first, [parity], stop.
`ifdef UART_PARITY_EN
    tx_data = 8'h07;
    exp_tx  = 11'b11000001110;
    nbits   = 11;
`else
    tx_data = 8'hA5;
    exp_tx  = 11'b01101001010;
    nbits   = 10;
`endif
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    for (int k = 1; k <= nbits * CPB + 1; k++) begin
      if (k > 1) @(negedge sys_clk);
      if (k <= nbits * CPB && ((k - 1) % CPB == 0 || k % CPB == 0))
        check($sformatf("tx_bit%0d_k%0d", (k - 1) / CPB, k), 32'(tx_serial),
              32'(exp_tx[(k - 1) / CPB]));
      if (k == 1) check("tx_ready_busy", 32'(tx_ready), 0);
      if (k == 40) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end
      if (k == 41) tx_valid = 1'b0;
      if (k == nbits * CPB - 1) check("tx_done_early", 32'(tx_done), 0);
      if (k == nbits * CPB) check("tx_done_pulse", 32'(tx_done), 1);
      if (k == nbits * CPB + 1) begin
        check("tx_ready_back", 32'(tx_ready), 1);
        check("tx_done_low", 32'(tx_done), 0);
      end
    end
    repeat (4) @(negedge sys_clk);
    check("tx_idle_after", 32'(tx_serial), 1);

    // Receive three frames without popping, then drain in order.
    send_frame(8'h3C, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) @(negedge sys_clk);
    pop_check("lb0", 8'h3C);
    pop_check("lb1", 8'h00);
    pop_check("lb2", 8'hFF);
    check("lb_empty", 32'(rx_valid), 0);
    check("lb_frame_err", 32'(rx_frame_err), 0);
    check("lb_overrun", 32'(rx_overrun), 0);

    // Overrun: fifth frame lands on a full FIFO.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    repeat (4) @(negedge sys_clk);
    check("ovr_not_yet", 32'(rx_overrun), 0);
    send_frame(8'h55, 1'b1);
    repeat (4) @(negedge sys_clk);
    check("ovr_set", 32'(rx_overrun), 1);
    clear_errors();
    check("ovr_cleared", 32'(rx_overrun), 0);
    pop_check("ovr0", 8'h11);
    pop_check("ovr1", 8'h22);
    pop_check("ovr2", 8'h33);
    pop_check("ovr3", 8'h44);
    check("ovr_empty", 32'(rx_valid), 0);

    // Framing error: stop bit low, word discarded.
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge sys_clk);
    check("ferr_set", 32'(rx_frame_err), 1);
    check("ferr_no_write", 32'(rx_valid), 0);
    clear_errors();
    check("ferr_cleared", 32'(rx_frame_err), 0);

    // False start: 6-cycle glitch, then a good frame.
    rx_serial = 1'b0;
    repeat (6) @(negedge sys_clk);
    rx_serial = 1'b1;
    repeat (40) @(negedge sys_clk);
    check("glitch_no_write", 32'(rx_valid), 0);
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge sys_clk);
    pop_check("after_glitch", 8'h81);
    check("glitch_ferr", 32'(rx_frame_err), 0);

`ifdef UART_PARITY_EN
    // Parity error: 8'h07 with parity bit 0.
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    repeat (4) @(negedge sys_clk);
    check("perr_set", 32'(rx_parity_err), 1);
    check("perr_no_write", 32'(rx_valid), 0);
    clear_errors();
    check("perr_cleared", 32'(rx_parity_err), 0);
`endif

    // Reset asserted during bit 3 of an all-zero frame.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    repeat (3 * CPB + 6) @(negedge sys_clk);
    check("rst_mid_pre", 32'(tx_serial), 0);
    sys_rst_l = 1'b0;
    #1;
    check("rst_mid_serial", 32'(tx_serial), 1);
    check("rst_mid_ready", 32'(tx_ready), 1);
    @(negedge sys_clk);
    sys_rst_l = 1'b1;
    repeat (20) @(negedge sys_clk);
    check("rst_post_serial", 32'(tx_serial), 1);
    check("rst_post_ready", 32'(tx_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
